// File: rtl/jt6295_pkg.sv
// Shared types and constants for the jt6295 command sequencer.
package jt6295_pkg;

  localparam int unsigned HDR_BYTES  = 6;
  localparam int unsigned HDR_STRIDE = 8;
  localparam int unsigned NCH        = 4;
  localparam int unsigned HDR_ADDR_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT2 = 2'd1,
    ST_FETCH = 2'd2,
    ST_ISSUE = 2'd3
  } state_t;

  typedef struct packed {
    logic [HDR_ADDR_W-1:0] start;
    logic [HDR_ADDR_W-1:0] stop;
  } hdr_t;

  // Merge one header byte into the phrase header, big-endian, 18-bit addresses.
  function automatic hdr_t hdr_put(input hdr_t h, input logic [2:0] idx, input logic [7:0] b);
    hdr_t r;
    r = h;
    case (idx)
      3'd0:    r.start[17:16] = b[1:0];
      3'd1:    r.start[15:8]  = b;
      3'd2:    r.start[7:0]   = b;
      3'd3:    r.stop[17:16]  = b[1:0];
      3'd4:    r.stop[15:8]   = b;
      default: r.stop[7:0]    = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jt6295_cmd.sv
// MSM6295-style command decoder: CPU byte writes -> header fetch -> channel start/stop pulses.
module jt6295_cmd
  import jt6295_pkg::*;
#(
  parameter int unsigned     AW       = 18,
  parameter logic [AW-1:0]   HDR_BASE = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_n,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic          rom_ok,
  input  logic [7:0]    rom_data,
  input  logic [3:0]    busy,
  output logic [3:0]    ch_start,
  output logic [3:0]    ch_stop,
  output logic [AW-1:0] start_addr,
  output logic [AW-1:0] stop_addr,
  output logic [3:0]    ch_att
);

  state_t           state, state_d;
  logic             wr_n_q;
  logic [6:0]       phrase, phrase_d;
  logic [NCH-1:0]   mask, mask_d;
  logic [3:0]       att, att_d;
  logic [2:0]       idx, idx_d;
  hdr_t             hdr, hdr_d;
  logic             rom_cs_d;
  logic [AW-1:0]    rom_addr_d;
  logic [3:0]       ch_start_d, ch_stop_d, ch_att_d;
  logic [AW-1:0]    start_addr_d, stop_addr_d;
  logic             wr_ev;

  // A write completes on the rising edge of wr_n; din is taken in that cycle.
  assign wr_ev = !wr_n_q && wr_n;

  // Status byte mirrors the channel busy flags.
  assign dout = {4'hF, busy};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wr_n_q     <= 1'b1;
      phrase     <= '0;
      mask       <= '0;
      att        <= '0;
      idx        <= '0;
      hdr        <= '0;
      rom_cs     <= 1'b0;
      rom_addr   <= '0;
      ch_start   <= '0;
      ch_stop    <= '0;
      start_addr <= '0;
      stop_addr  <= '0;
      ch_att     <= '0;
    end else begin
      state      <= state_d;
      wr_n_q     <= wr_n;
      phrase     <= phrase_d;
      mask       <= mask_d;
      att        <= att_d;
      idx        <= idx_d;
      hdr        <= hdr_d;
      rom_cs     <= rom_cs_d;
      rom_addr   <= rom_addr_d;
      ch_start   <= ch_start_d;
      ch_stop    <= ch_stop_d;
      start_addr <= start_addr_d;
      stop_addr  <= stop_addr_d;
      ch_att     <= ch_att_d;
    end
  end

  // Command decode, header fetch sequencing and channel pulse generation.
  always_comb begin
    state_d      = state;
    phrase_d     = phrase;
    mask_d       = mask;
    att_d        = att;
    idx_d        = idx;
    hdr_d        = hdr;
    rom_cs_d     = rom_cs;
    rom_addr_d   = rom_addr;
    ch_start_d   = '0;
    ch_stop_d    = '0;
    start_addr_d = start_addr;
    stop_addr_d  = stop_addr;
    ch_att_d     = ch_att;

    // Stop bytes act at once in any state except when a second byte is due.
    if (wr_ev && !din[7] && state != ST_WAIT2) begin
      ch_stop_d = din[6:3];
    end

    case (state)
      ST_IDLE: begin
        if (wr_ev && din[7]) begin
          phrase_d = din[6:0];
          state_d  = ST_WAIT2;
        end
      end
      ST_WAIT2: begin
        if (wr_ev) begin
          mask_d = din[7:4];
          att_d  = din[3:0];
          if (phrase == 7'd0 || din[7:4] == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_FETCH;
            idx_d    = 3'd0;
            rom_cs_d = 1'b0;
          end
        end
      end
      ST_FETCH: begin
        // rom_cs low for one cycle before each byte request.
        if (!rom_cs) begin
          rom_cs_d   = 1'b1;
          rom_addr_d = HDR_BASE + AW'(32'(phrase) * HDR_STRIDE) + AW'(idx);
        end else if (rom_ok) begin
          rom_cs_d = 1'b0;
          hdr_d    = hdr_put(hdr, idx, rom_data);
          if (idx == 3'(HDR_BYTES - 1)) begin
            state_d = ST_ISSUE;
          end else begin
            idx_d = idx + 3'd1;
          end
        end
      end
      ST_ISSUE: begin
        // Busy channels are skipped without notice, like the original chip.
        ch_start_d   = mask & ~busy;
        start_addr_d = AW'(hdr.start);
        stop_addr_d  = AW'(hdr.stop);
        ch_att_d     = att;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jt6295_cmd.sv
// Self-checking bench for jt6295_cmd with a latency-programmable ROM model.
module tb_jt6295_cmd;

  localparam int unsigned AW = 18;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_n;
  logic [7:0]    din;
  logic [7:0]    dout;
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic          rom_ok = 1'b0;
  logic [7:0]    rom_data = 8'h00;
  logic [3:0]    busy;
  logic [3:0]    ch_start, ch_stop, ch_att;
  logic [AW-1:0] start_addr, stop_addr;

  jt6295_cmd #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .din(din), .dout(dout),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
    .busy(busy), .ch_start(ch_start), .ch_stop(ch_stop),
    .start_addr(start_addr), .stop_addr(stop_addr), .ch_att(ch_att)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM: rom_ok rises rom_lat clocks after rom_cs is first seen, drops with rom_cs.
  logic [7:0] rom_mem [0:1023];
  int rom_lat = 1;
  int wait_cnt = 0;
  always @(posedge clk) begin
    if (rom_cs && !rom_ok) begin
      if (wait_cnt + 1 >= rom_lat) begin
        rom_ok   <= 1'b1;
        rom_data <= rom_mem[10'(rom_addr)];
        wait_cnt <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      rom_ok   <= 1'b0;
      wait_cnt <= 0;
    end
  end

  // Event monitor, sampled mid-cycle.
  int start_cnt = 0, stop_cnt = 0, cs_rises = 0, start_cyc = 0;
  logic [3:0] start_val = 4'h0, stop_val = 4'h0, att_val = 4'h0;
  logic [AW-1:0] sa_val = '0, pa_val = '0;
  logic cs_prev = 1'b0;
  always @(negedge clk) begin
    if (ch_start != 4'h0) begin
      start_cnt <= start_cnt + 1;
      start_val <= ch_start;
      start_cyc <= cyc;
      sa_val    <= start_addr;
      pa_val    <= stop_addr;
      att_val   <= ch_att;
    end
    if (ch_stop != 4'h0) begin
      stop_cnt <= stop_cnt + 1;
      stop_val <= ch_stop;
    end
    if (rom_cs && !cs_prev) cs_rises <= cs_rises + 1;
    cs_prev <= rom_cs;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [7:0] b, output int rc);
    @(negedge clk);
    din  = b;
    wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1;
    rc   = cyc;
    @(negedge clk);
  endtask

  function automatic logic [17:0] hdr_addr(input int base);
    return {rom_mem[10'(base)][1:0], rom_mem[10'(base + 1)], rom_mem[10'(base + 2)]};
  endfunction

  task automatic wait_start(input int s0, input int budget);
    for (int i = 0; i < budget && start_cnt == s0; i++) @(negedge clk);
    idle(3);
  endtask

  // Full phrase command checked against header table and busy mask.
  task automatic run_phrase(input logic [6:0] ph, input logic [3:0] m, input logic [3:0] a,
                            input logic [3:0] bz, input int lat, input string tag);
    int s0, c0, rc, explat;
    logic [3:0] exp_start;
    logic fetch;
    busy      = bz;
    rom_lat   = lat;
    s0        = start_cnt;
    c0        = cs_rises;
    fetch     = (ph != 7'd0) && (m != 4'd0);
    exp_start = fetch ? (m & ~bz) : 4'h0;
    explat    = 1 + 6 * (lat + 2) + 1;
    cpu_write({1'b1, ph}, rc);
    cpu_write({m, a}, rc);
    wait_start(s0, explat + 20);
    chk({tag, "_cs_count"}, 32'(cs_rises - c0), fetch ? 32'd6 : 32'd0);
    chk({tag, "_start_count"}, 32'(start_cnt - s0), (exp_start != 4'h0) ? 32'd1 : 32'd0);
    if (exp_start != 4'h0 && start_cnt != s0) begin
      chk({tag, "_latency"}, 32'(start_cyc - rc), 32'(explat));
      chk({tag, "_start"}, 32'(start_val), 32'(exp_start));
      chk({tag, "_start_addr"}, 32'(sa_val), 32'(hdr_addr(int'(ph) * 8)));
      chk({tag, "_stop_addr"}, 32'(pa_val), 32'(hdr_addr(int'(ph) * 8 + 3)));
      chk({tag, "_att"}, 32'(att_val), 32'(a));
    end
  endtask

  task automatic stop_write(input logic [7:0] b, input string tag);
    int s0, c0, rc;
    logic [3:0] exp_stop;
    s0 = stop_cnt;
    c0 = cs_rises;
    exp_stop = 4'((b >> 3) & 8'h0F);
    cpu_write(b, rc);
    idle(3);
    chk({tag, "_stop_count"}, 32'(stop_cnt - s0), (exp_stop != 4'h0) ? 32'd1 : 32'd0);
    if (exp_stop != 4'h0) chk({tag, "_stop_val"}, 32'(stop_val), 32'(exp_stop));
    chk({tag, "_no_cs"}, 32'(cs_rises - c0), 32'd0);
  endtask

  initial begin
    int rc, s0, c0, t0;
    rst_n = 1'b0;
    wr_n  = 1'b1;
    din   = 8'h00;
    busy  = 4'h0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 8'($urandom);
    rom_mem[8]  = 8'h01; rom_mem[9]  = 8'h23; rom_mem[10] = 8'h45;
    rom_mem[11] = 8'h01; rom_mem[12] = 8'h67; rom_mem[13] = 8'h89;

    idle(3);
    chk("rst_rom_cs", 32'(rom_cs), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_ch_start", 32'(ch_start), 32'd0);
    chk("rst_ch_stop", 32'(ch_stop), 32'd0);
    chk("rst_att", 32'(ch_att), 32'd0);
    chk("dout_idle", 32'(dout), 32'h0F0);
    rst_n = 1'b1;
    idle(2);

    run_phrase(7'd1, 4'h1, 4'h3, 4'h0, 1, "p1_basic");
    busy = 4'b0101;
    idle(1);
    chk("dout_busy", 32'(dout), 32'h0F5);
    run_phrase(7'd1, 4'hF, 4'h0, 4'b0101, 1, "p1_busy");

    busy = 4'h0;
    run_phrase(7'd0, 4'hF, 4'h0, 4'h0, 1, "phrase0");
    stop_write(8'h48, "stop_idle");
    run_phrase(7'd5, 4'h0, 4'h0, 4'h0, 1, "mask0");
    stop_write(8'h48, "stop_after_mask0");

    // Stop command in the middle of a header fetch.
    rom_lat = 1;
    s0 = start_cnt;
    c0 = cs_rises;
    cpu_write(8'h81, rc);
    cpu_write(8'h13, rc);
    t0 = stop_cnt;
    cpu_write(8'h28, s0 == s0 ? rc : rc);
    rc = rc - 3;
    idle(2);
    chk("fetch_stop_count", 32'(stop_cnt - t0), 32'd1);
    chk("fetch_stop_val", 32'(stop_val), 32'b0101);
    wait_start(s0, 60);
    chk("fetch_stop_start_count", 32'(start_cnt - s0), 32'd1);
    chk("fetch_stop_start_addr", 32'(sa_val), 32'h12345);
    chk("fetch_stop_cs_count", 32'(cs_rises - c0), 32'd6);

    // Phrase select during fetch is discarded; the following 0x10 is a stop.
    s0 = start_cnt;
    c0 = cs_rises;
    cpu_write(8'h81, rc);
    cpu_write(8'h13, rc);
    cpu_write(8'h82, rc);
    wait_start(s0, 60);
    chk("ign_start_count", 32'(start_cnt - s0), 32'd1);
    chk("ign_start_addr", 32'(sa_val), 32'h12345);
    chk("ign_stop_addr", 32'(pa_val), 32'h16789);
    chk("ign_cs_count", 32'(cs_rises - c0), 32'd6);
    stop_write(8'h10, "ign_followup");

    // Asynchronous reset with the fourth header byte outstanding.
    rom_lat = 1;
    c0 = cs_rises;
    cpu_write(8'h81, rc);
    cpu_write(8'h13, rc);
    for (int i = 0; i < 200 && cs_rises < c0 + 4; i++) @(posedge clk);
    chk("midfetch_idx3", 32'(cs_rises - c0), 32'd4);
    #1;
    chk("midfetch_cs_pre", 32'(rom_cs), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midfetch_cs", 32'(rom_cs), 32'd0);
    chk("midfetch_addr", 32'(rom_addr), 32'd0);
    chk("midfetch_start_addr", 32'(start_addr), 32'd0);
    chk("midfetch_stop_addr", 32'(stop_addr), 32'd0);
    chk("midfetch_att", 32'(ch_att), 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(2);
    s0 = start_cnt;
    stop_write(8'h10, "post_reset_idle");
    idle(30);
    chk("post_reset_no_start", 32'(start_cnt - s0), 32'd0);

    // Randomized commands and stops against the header-table model.
    for (int k = 0; k < 10; k++) begin
      run_phrase(7'($urandom_range(1, 127)), 4'($urandom), 4'($urandom), 4'($urandom),
                 int'($urandom_range(1, 3)), "rnd_phrase");
      stop_write(8'($urandom_range(0, 127)), "rnd_stop");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
